mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit fed by the EXE/MEM pipeline register.
- Takes the registered ALU result as the effective address and the registered rs2 value as store data.
- Runs a request/grant/response handshake with data memory and stalls the pipeline until the access completes.
- Returns aligned, sign- or zero-extended load data to the write-back path.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32 (four byte lanes)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ex_valid  input  1  EXE/MEM register holds a valid instruction
- ex_load  input  1  instruction is a load
- ex_store  input  1  instruction is a store
- ex_funct3  input  3  RV32I funct3: [1:0] size (0=B, 1=H, 2/3=W), [2] unsigned (loads only)
- ex_addr  input  32  effective address (registered ALU result)
- ex_wdata  input  32  store data (registered rs2)
- stall  output  1  freeze the IF/ID/EXE/MEM registers
- dm_req  output  1  memory request valid
- dm_we  output  1  1 = write
- dm_addr  output  32  word-aligned address, {ex_addr[31:2],2'b00}
- dm_wstrb  output  4  byte write enables
- dm_wdata  output  32  lane-replicated store data
- dm_gnt  input  1  memory accepted the request
- dm_rvalid  input  1  read data valid / write acknowledge
- dm_rdata  input  32  raw word read data
- wb_valid  output  1  one-cycle pulse: access finished
- wb_rdata  output  32  extended load data (0 for stores)
- misalign  output  1  one-cycle pulse: misaligned access dropped

Behaviour:
- Reset: state=IDLE. dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata, wb_valid, wb_rdata, misalign all 0. Reset is asynchronous, so dm_req drops immediately even mid-access; any in-flight response is discarded.
- start = ex_valid & (ex_load | ex_store) in IDLE.
  - If ex_load and ex_store are both set, treat as a load.
- Alignment:
  - H is misaligned if addr[0]=1.
  - W is misaligned if addr[1:0]!=0.
  - On a misaligned start: no memory access, no stall, misalign=1 next cycle for one cycle, stay in IDLE.
- FSM:
  - IDLE -> REQ on an aligned start. Capture addr, size, unsigned flag, load/store, wdata/wstrb. dm_req=1 from the next cycle.
  - REQ: hold dm_req and every dm_* signal stable until dm_gnt. On gnt: dm_req=0, go to WAIT.
  - WAIT: on dm_rvalid, register wb_valid=1 (and wb_rdata for loads), return to IDLE.
  - dm_rvalid outside WAIT is ignored. Memory guarantees rvalid comes at least 1 cycle after gnt.
- stall (combinational) = (IDLE & aligned start) | REQ | (WAIT & !dm_rvalid).
  - The pipeline therefore advances in the same cycle rvalid arrives.
  - wb_valid pulses the following cycle. Back-to-back accesses are allowed: IDLE can start again in that same cycle.
- Store lanes, o = addr[1:0]:
  - SB: wdata = {4{b}}, wstrb = 4'b0001 << o
  - SH: wdata = {2{h}}, wstrb = o[1] ? 1100 : 0011
  - SW: wdata = wdata, wstrb = 1111
  - Loads: wstrb = 0000, dm_we = 0.
- Load extract: shifted = dm_rdata >> (8*o).
  - LB/LBU: sign- or zero-extend shifted[7:0].
  - LH/LHU: sign- or zero-extend shifted[15:0].
  - LW: full word.
- wb_rdata holds its value until the next wb_valid. It is written to 0 on store completion.
- Non-memory instructions (ex_valid with neither flag set): no action, no stall.

Test Plan:
- LW at 0x100: gnt on cycle 1, rvalid on cycle 3 with rdata 0xDEADBEEF.
  - stall high for cycles 0–2, low on cycle 3.
  - wb_valid on cycle 4 with wb_rdata=0xDEADBEEF.
  - dm_addr=0x100, wstrb=0.
- SB addr 0x203, wdata 0x000000A5.
  - dm_we=1, dm_addr=0x200, wstrb=1000, dm_wdata=0xA5A5A5A5.
  - Completes on ack; wb_rdata=0.
- LB/LBU/LH at offsets 1/1/2 with rdata 0x80F0_7F01:
  - LB -> 0x0000007F
  - LBU -> 0x0000007F
  - LH -> 0xFFFF80F0
  - LB at offset 3 -> 0xFFFFFF80
- LW at 0x102 and SH at 0x101:
  - misalign pulses 1 cycle each.
  - dm_req never asserts, stall stays 0.
- dm_gnt held low for 5 cycles:
  - dm_req, dm_addr, dm_wdata, dm_wstrb stay stable.
  - stall stays 1 throughout.
  - Follow with back-to-back SW then LW: no idle gap needed.
- Assert rst while in WAIT:
  - dm_req, stall, and all outputs go to 0 immediately.
  - A later dm_rvalid produces no wb_valid.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/grant/response handshake with data memory,
// stalls the pipeline for the access and returns aligned, extended load data.
module mem_stage_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wstrb,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            r_state, w_next;
  logic              w_start, w_mis, w_go, w_mis_start;
  logic [1:0]        w_size, w_off;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_uns, r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_wb_valid, r_misalign;
  logic [DATA_W-1:0] r_wb_rdata;

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] size, input logic [DATA_W-1:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] rdata,
                                                     input logic [1:0] size, input logic uns,
                                                     input logic [1:0] off);
    logic [DATA_W-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'd0:    return {{24{~uns & sh[7]}}, sh[7:0]};
      2'd1:    return {{16{~uns & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign w_size      = ex_funct3[1:0];
  assign w_off       = ex_addr[1:0];
  assign w_start     = ex_valid & (ex_load | ex_store);
  assign w_mis       = (w_size == 2'd1) ? w_off[0] : (w_size[1] ? (w_off != 2'd0) : 1'b0);
  assign w_go        = (r_state == S_IDLE) & w_start & ~w_mis;
  assign w_mis_start = (r_state == S_IDLE) & w_start & w_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_REQ;
      S_REQ:   if (dm_gnt) w_next = S_WAIT;
      S_WAIT:  if (dm_rvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs; stall releases in the cycle the response arrives.
  always_comb begin
    dm_req = 1'b0;
    stall  = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_go & ~rst;
      S_REQ:   begin dm_req = 1'b1; stall = 1'b1; end
      S_WAIT:  stall = ~dm_rvalid;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rdata <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_mis_start;
      r_wb_valid <= (r_state == S_WAIT) & dm_rvalid;
      if (w_go) begin
        r_addr  <= ex_addr;
        r_size  <= w_size;
        r_uns   <= ex_funct3[2];
        // A load wins when both load and store flags are set.
        r_we    <= ex_store & ~ex_load;
        r_wdata <= lane_data(w_size, ex_wdata);
        r_wstrb <= (ex_store & ~ex_load) ? lane_strb(w_size, w_off) : 4'b0000;
      end
      if ((r_state == S_WAIT) & dm_rvalid)
        r_wb_rdata <= r_we ? '0 : load_extract(dm_rdata, r_size, r_uns, r_addr[1:0]);
    end
  end

  assign dm_we    = r_we;
  assign dm_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign dm_wstrb = r_wstrb;
  assign dm_wdata = r_wdata;
  assign wb_valid = r_wb_valid;
  assign wb_rdata = r_wb_rdata;
  assign misalign = r_misalign;

endmodule
